sauber_cfg_sequencer: RTL and testbench

SAUBER_CFG_SEQUENCER -- requirements
Module: sauber_cfg_sequencer

---
 rtl/sauber_cfg_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_sauber_cfg_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sauber_cfg_sequencer.sv
// Configuration-load sequencer: pulls bitstream words from a ready/valid source, writes
// each to the fabric with a setup/strobe/hold envelope, then sequences the RNG and fabric resets.
module sauber_cfg_sequencer #(
  parameter int NUM_WORDS  = 5285,
  parameter int SETTLE_CYC = 10,
  parameter int FRST_CYC   = 1
) (
  input  logic        CLK,
  input  logic        rst_async_full,
  input  logic        start,
  input  logic        restart,
  input  logic [31:0] word_data,
  input  logic        word_valid,
  output logic        word_ready,
  output logic [31:0] SelfWriteData,
  output logic        SelfWriteStrobe,
  output logic        rst_sync_fabric,
  output logic        rst_sync_rng,
  output logic        cfg_done,
  output logic        busy
);

  localparam int SETUP_LEN  = 2;
  localparam int HOLD_LEN   = 2;
  localparam int SETTLE_LEN = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
  localparam int FRST_LEN   = (FRST_CYC < 1) ? 1 : FRST_CYC;
  localparam int TMAX_A     = (SETTLE_LEN > FRST_LEN) ? SETTLE_LEN : FRST_LEN;
  localparam int TMAX       = (TMAX_A > SETUP_LEN) ? TMAX_A : SETUP_LEN;
  localparam int TW         = $clog2(TMAX + 1);
  localparam int CW         = $clog2(NUM_WORDS + 1);

  localparam logic [CW-1:0] NUM_W       = CW'(NUM_WORDS);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [TW-1:0] T_ZERO      = TW'(0);
  localparam logic [TW-1:0] T_ONE       = TW'(1);
  localparam logic [TW-1:0] SETUP_LAST  = TW'(SETUP_LEN - 1);
  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_LEN - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_LEN - 1);
  localparam logic [TW-1:0] FRST_LAST   = TW'(FRST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_WORD = 3'd1,
    SETUP     = 3'd2,
    STROBE    = 3'd3,
    HOLD      = 3'd4,
    SETTLE    = 3'd5,
    FAB_RST   = 3'd6,
    RUN       = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [31:0]   data_q, data_d;
  logic          ready_q, ready_d;
  logic          strobe_q, strobe_d;
  logic          fab_q, fab_d;
  logic          rng_q, rng_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  // Next-state, word counter, phase timer and data latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tmr_d   = tmr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT_WORD;
          count_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_WORD: begin
        if (word_valid && ready_q) begin
          data_d  = word_data;
          state_d = SETUP;
          tmr_d   = T_ZERO;
        end else begin
          state_d = WAIT_WORD;
        end
      end
      SETUP: begin
        if (tmr_q == SETUP_LAST) begin
          state_d = STROBE;
          tmr_d   = T_ZERO;
        end else begin
          tmr_d = tmr_q + T_ONE;
        end
      end
      STROBE: begin
        // Saturating: the count must never wrap back past NUM_WORDS.
        if (count_q != NUM_W) begin
          count_d = count_q + CNT_ONE;
        end else begin
          count_d = count_q;
        end
        state_d = HOLD;
        tmr_d   = T_ZERO;
      end
      HOLD: begin
        if (tmr_q == HOLD_LAST) begin
          state_d = (count_q == NUM_W) ? SETTLE : WAIT_WORD;
          tmr_d   = T_ZERO;
        end else begin
          tmr_d = tmr_q + T_ONE;
        end
      end
      SETTLE: begin
        if (tmr_q == SETTLE_LAST) begin
          state_d = FAB_RST;
          tmr_d   = T_ZERO;
        end else begin
          tmr_d = tmr_q + T_ONE;
        end
      end
      FAB_RST: begin
        if (tmr_q == FRST_LAST) begin
          state_d = RUN;
          tmr_d   = T_ZERO;
        end else begin
          tmr_d = tmr_q + T_ONE;
        end
      end
      RUN: begin
        if (restart) begin
          state_d = FAB_RST;
          tmr_d   = T_ZERO;
        end else if (start) begin
          state_d = WAIT_WORD;
          count_d = '0;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        tmr_d   = T_ZERO;
      end
    endcase
  end

  // Outputs are registered decodes of the next state so they change exactly with the state.
  always_comb begin
    ready_d  = (state_d == WAIT_WORD);
    strobe_d = (state_d == STROBE);
    fab_d    = (state_d != RUN);
    rng_d    = !((state_d == SETTLE) || (state_d == FAB_RST) || (state_d == RUN));
    done_d   = (state_d == RUN);
    busy_d   = !((state_d == IDLE) || (state_d == RUN));
  end

  // State and output registers with asynchronous full reset.
  always_ff @(posedge CLK or posedge rst_async_full) begin
    if (rst_async_full) begin
      state_q  <= IDLE;
      count_q  <= '0;
      tmr_q    <= T_ZERO;
      data_q   <= 32'h0000_0000;
      ready_q  <= 1'b0;
      strobe_q <= 1'b0;
      fab_q    <= 1'b1;
      rng_q    <= 1'b1;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      tmr_q    <= tmr_d;
      data_q   <= data_d;
      ready_q  <= ready_d;
      strobe_q <= strobe_d;
      fab_q    <= fab_d;
      rng_q    <= rng_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign word_ready      = ready_q;
  assign SelfWriteData   = data_q;
  assign SelfWriteStrobe = strobe_q;
  assign rst_sync_fabric = fab_q;
  assign rst_sync_rng    = rng_q;
  assign cfg_done        = done_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_sauber_cfg_sequencer.sv
// Bench for sauber_cfg_sequencer: a 3-word instance driven from a vector table and
// hand-written corner sequences, plus a default-size instance for a full-length load.
module tb_sauber_cfg_sequencer;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst, start, restart, word_valid;
  logic [31:0] word_data;
  logic        word_ready, SelfWriteStrobe, rst_sync_fabric, rst_sync_rng, cfg_done, busy;
  logic [31:0] SelfWriteData;

  logic        rst_b, start_b, restart_b, word_valid_b;
  logic [31:0] word_data_b;
  logic        word_ready_b, strobe_b, fab_b, rng_b, done_b, busy_b;
  logic [31:0] data_b;

  sauber_cfg_sequencer #(.NUM_WORDS(3), .SETTLE_CYC(10), .FRST_CYC(1)) dut (
    .CLK(CLK), .rst_async_full(rst), .start(start), .restart(restart),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .SelfWriteData(SelfWriteData), .SelfWriteStrobe(SelfWriteStrobe),
    .rst_sync_fabric(rst_sync_fabric), .rst_sync_rng(rst_sync_rng),
    .cfg_done(cfg_done), .busy(busy)
  );

  sauber_cfg_sequencer dut_big (
    .CLK(CLK), .rst_async_full(rst_b), .start(start_b), .restart(restart_b),
    .word_data(word_data_b), .word_valid(word_valid_b), .word_ready(word_ready_b),
    .SelfWriteData(data_b), .SelfWriteStrobe(strobe_b),
    .rst_sync_fabric(fab_b), .rst_sync_rng(rng_b),
    .cfg_done(done_b), .busy(busy_b)
  );

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [31:0] words [3] = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
  logic [31:0] exp_q [$];
  int  src_idx = 0;
  bit  src_en = 1'b0;
  bit  gap_mode = 1'b0;
  int  gap_left = 0;
  int  acc_cyc = 0;
  int  strobe_cnt = 0;

  typedef struct {
    int          c;
    logic [5:0]  flags;   // {ready, strobe, fabric, rng, done, busy}
    logic [31:0] data;
  } row_t;
  row_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] flags_now();
    return {26'd0, word_ready, SelfWriteStrobe, rst_sync_fabric, rst_sync_rng, cfg_done, busy};
  endfunction

  // Advance one cycle; sample at negedge, run the source and the strobe scoreboard.
  task automatic tick();
    bit will_acc;
    will_acc = word_valid && word_ready && !rst;
    @(negedge CLK);
    if (will_acc) begin
      exp_q.push_back(word_data);
      acc_cyc = cyc;
      src_idx++;
      if (gap_mode && src_idx == 1) gap_left = 7;
    end else if (gap_left > 0) begin
      gap_left--;
    end
    if (SelfWriteStrobe) begin
      strobe_cnt++;
      if (exp_q.size() == 0) chk("strobe_unexpected", 32'd1, 32'd0);
      else chk("strobe_data", SelfWriteData, exp_q.pop_front());
      chk("strobe_latency", 32'(cyc - acc_cyc), 32'd2);
    end
    word_valid = src_en && (src_idx < 3) && (gap_left == 0);
    word_data  = (src_idx < 3) ? words[src_idx] : 32'h0;
  endtask

  task automatic run_to_done(input string name, input int limit);
    int n = 0;
    while (!cfg_done && n < limit) begin
      tick();
      n++;
    end
    chk(name, {31'd0, cfg_done}, 32'd1);
  endtask

  initial begin
    int ti;
    int n;
    int big_acc, big_str, big_bad;
    bit wa;

    tbl[0]  = '{0,  6'b101101, 32'h0};
    tbl[1]  = '{1,  6'b001101, 32'h11223344};
    tbl[2]  = '{3,  6'b011101, 32'h11223344};
    tbl[3]  = '{5,  6'b001101, 32'h11223344};
    tbl[4]  = '{6,  6'b101101, 32'h11223344};
    tbl[5]  = '{7,  6'b001101, 32'h55667788};
    tbl[6]  = '{9,  6'b011101, 32'h55667788};
    tbl[7]  = '{15, 6'b011101, 32'h99AABBCC};
    tbl[8]  = '{17, 6'b001101, 32'h99AABBCC};
    tbl[9]  = '{18, 6'b001001, 32'h99AABBCC};
    tbl[10] = '{27, 6'b001001, 32'h99AABBCC};
    tbl[11] = '{28, 6'b001001, 32'h99AABBCC};
    tbl[12] = '{29, 6'b000010, 32'h99AABBCC};
    tbl[13] = '{32, 6'b000010, 32'h99AABBCC};

    rst = 1'b1; start = 1'b0; restart = 1'b0; word_valid = 1'b0; word_data = 32'h0;
    rst_b = 1'b1; start_b = 1'b0; restart_b = 1'b0; word_valid_b = 1'b0; word_data_b = 32'h0;

    // Reset state
    tick(); tick();
    chk("reset_flags", flags_now(), {26'd0, 6'b001100});
    chk("reset_data", SelfWriteData, 32'h0);
    rst = 1'b0;
    tick();
    chk("idle_flags", flags_now(), {26'd0, 6'b001100});

    // Basic 3-word load from the vector table
    src_en = 1'b1; src_idx = 0;
    word_valid = 1'b1; word_data = words[0];
    start = 1'b1; tick(); start = 1'b0;
    ti = 0;
    for (int c = 0; c <= 32; c++) begin
      if (ti < 14 && tbl[ti].c == c) begin
        chk($sformatf("row_c%0d_flags", c), flags_now(), {26'd0, tbl[ti].flags});
        chk($sformatf("row_c%0d_data", c), SelfWriteData, tbl[ti].data);
        ti++;
      end
      tick();
    end
    chk("basic_strobes", 32'(strobe_cnt), 32'd3);
    chk("basic_queue_empty", 32'(exp_q.size()), 32'd0);

    // Restart pulse in RUN
    restart = 1'b1; tick(); restart = 1'b0;
    chk("restart_pulse", flags_now(), {26'd0, 6'b001001});
    tick();
    chk("restart_back_run", flags_now(), {26'd0, 6'b000010});

    // Restart wins over start in RUN
    restart = 1'b1; start = 1'b1; tick(); restart = 1'b0; start = 1'b0;
    chk("prio_restart", flags_now(), {26'd0, 6'b001001});
    tick();
    chk("prio_back_run", flags_now(), {26'd0, 6'b000010});

    // Reload from RUN with a source gap and ignored control pulses
    strobe_cnt = 0; src_idx = 0; gap_mode = 1'b1;
    word_valid = 1'b1; word_data = words[0];
    start = 1'b1; tick(); start = 1'b0;
    chk("reload_a0", flags_now(), {26'd0, 6'b101101});
    tick();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("setup_start_ignored", flags_now(), {26'd0, 6'b011101});
    tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("hold_start_ignored", flags_now(), {26'd0, 6'b001101});
    chk("hold_data", SelfWriteData, 32'h11223344);
    tick();
    restart = 1'b1; tick(); restart = 1'b0;
    chk("gap_wait_flags", flags_now(), {26'd0, 6'b101101});
    chk("gap_data_held", SelfWriteData, 32'h11223344);
    gap_mode = 1'b0;
    run_to_done("gap_done", 200);
    chk("gap_strobes", 32'(strobe_cnt), 32'd3);

    // Asynchronous reset during the second strobe, then a clean reload
    strobe_cnt = 0; src_idx = 0;
    word_valid = 1'b1; word_data = words[0];
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!(strobe_cnt == 2 && SelfWriteStrobe) && n < 100) begin
      tick();
      n++;
    end
    chk("found_strobe2", {31'd0, SelfWriteStrobe}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_flags", flags_now(), {26'd0, 6'b001100});
    chk("async_rst_data", SelfWriteData, 32'h0);
    exp_q.delete(); src_idx = 0; word_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("post_rst_idle", flags_now(), {26'd0, 6'b001100});
    strobe_cnt = 0;
    word_valid = 1'b1; word_data = words[0];
    start = 1'b1; tick(); start = 1'b0;
    run_to_done("reload_done", 200);
    chk("reload_strobes", 32'(strobe_cnt), 32'd3);

    // Full-length load on the default-size instance
    @(negedge CLK);
    rst_b = 1'b0;
    @(negedge CLK);
    start_b = 1'b1;
    @(negedge CLK);
    start_b = 1'b0;
    big_acc = 0; big_str = 0; big_bad = 0;
    word_valid_b = 1'b1; word_data_b = {16'hA5A5, 16'h0000};
    for (int i = 0; i < 40000 && !done_b; i++) begin
      wa = word_valid_b && word_ready_b;
      @(negedge CLK);
      if (wa) begin
        big_acc++;
        word_data_b = {16'hA5A5, 16'(big_acc)};
      end
      if (strobe_b) begin
        if (data_b !== {16'hA5A5, 16'(big_str)}) big_bad++;
        big_str++;
      end
    end
    chk("big_done", {31'd0, done_b}, 32'd1);
    chk("big_strobes", 32'(big_str), 32'd5285);
    chk("big_accepts", 32'(big_acc), 32'd5285);
    chk("big_data_errors", 32'(big_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
